axi_bram_slave: RTL and testbench

AXI4 memory-mapped slave that terminates the 32-bit master port of the SystemC AXI bus-functional master and converts its bursts into accesses on a single-port BRAM. It sits directly downstream of the master's `m_axi_*` bus and gives simulation a real memory target for master-issued traffic. One transaction is in flight at a time; reads and writes are arbitrated fairly.

---
 rtl/axi_bram_slave_if.sv | 55 +++++
 rtl/axi_bram_slave.sv | 102 ++++++++++
 tb/tb_axi_bram_slave.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_bram_slave_if.sv
// axi_bram_slave_if: AXI4 slave channels plus the single-port BRAM port of axi_bram_slave
interface axi_bram_slave_if;
  logic [31:0] s_axi_awaddr;
  logic [7:0]  s_axi_awlen;
  logic [2:0]  s_axi_awsize;
  logic [1:0]  s_axi_awburst;
  logic [2:0]  s_axi_awprot;
  logic        s_axi_awlock;
  logic [3:0]  s_axi_awcache;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wlast;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [31:0] s_axi_araddr;
  logic [7:0]  s_axi_arlen;
  logic [2:0]  s_axi_arsize;
  logic [1:0]  s_axi_arburst;
  logic [2:0]  s_axi_arprot;
  logic        s_axi_arlock;
  logic [3:0]  s_axi_arcache;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic        bram_en;
  logic [3:0]  bram_we;
  logic [31:0] bram_addr;
  logic [31:0] bram_wrdata;
  logic [31:0] bram_rddata;
  modport slave (
    input  s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awprot, s_axi_awlock,
           s_axi_awcache, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arprot,
           s_axi_arlock, s_axi_arcache, s_axi_arvalid, s_axi_rready, bram_rddata,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid, s_axi_arready, s_axi_rdata,
           s_axi_rresp, s_axi_rlast, s_axi_rvalid, bram_en, bram_we, bram_addr, bram_wrdata
  );
  modport master (
    output s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awprot, s_axi_awlock,
           s_axi_awcache, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arprot,
           s_axi_arlock, s_axi_arcache, s_axi_arvalid, s_axi_rready, bram_rddata,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid, s_axi_arready, s_axi_rdata,
           s_axi_rresp, s_axi_rlast, s_axi_rvalid, bram_en, bram_we, bram_addr, bram_wrdata
  );
endinterface

// File: rtl/axi_bram_slave.sv
// axi_bram_slave: AXI4 burst slave serving one transaction at a time from a single-port BRAM
module axi_bram_slave #(
  parameter int C_ADDR_WIDTH = 12
) (
  input logic axi_aclk,
  input logic axi_areset,
  axi_bram_slave_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_ISSUE, RD_WAIT, RD_DATA} state_t;
  state_t state, state_nx;
  logic [C_ADDR_WIDTH-1:0] addr, addr_nx;
  logic [7:0] len, cnt;
  logic [2:0] size;
  logic [1:0] burst;
  logic err, last_wr, grant_w, grant_r, w_beat, r_beat, at_len, unused;
  // last_wr remembers the direction serviced last so a simultaneous request goes the other way
  assign grant_w = bus.s_axi_awvalid & (~bus.s_axi_arvalid | ~last_wr);
  assign grant_r = bus.s_axi_arvalid & ~grant_w;
  assign bus.s_axi_awready = (state == IDLE) & grant_w;
  assign bus.s_axi_arready = (state == IDLE) & grant_r;
  assign bus.s_axi_wready = state == WR_DATA;
  assign bus.s_axi_bvalid = state == WR_RESP;
  assign bus.s_axi_bresp = (bus.s_axi_bvalid & err) ? 2'b10 : 2'b00;
  assign bus.s_axi_rvalid = state == RD_DATA;
  assign bus.s_axi_rresp = 2'b00;
  assign at_len = cnt == len;
  assign bus.s_axi_rlast = bus.s_axi_rvalid & at_len;
  assign w_beat = bus.s_axi_wready & bus.s_axi_wvalid;
  assign r_beat = bus.s_axi_rvalid & bus.s_axi_rready;
  assign addr_nx = (burst == 2'b00) ? addr : addr + (C_ADDR_WIDTH'(1) << size);
  assign unused = ^{bus.s_axi_awaddr[31:C_ADDR_WIDTH], bus.s_axi_araddr[31:C_ADDR_WIDTH],
                    bus.s_axi_awprot, bus.s_axi_arprot, bus.s_axi_awlock, bus.s_axi_arlock,
                    bus.s_axi_awcache, bus.s_axi_arcache};
  always_ff @(posedge axi_aclk)
    state <= axi_areset ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = bus.s_axi_awready ? WR_DATA : bus.s_axi_arready ? RD_ISSUE : IDLE;
      WR_DATA:  state_nx = (w_beat && at_len) ? WR_RESP : WR_DATA;
      WR_RESP:  state_nx = bus.s_axi_bready ? IDLE : WR_RESP;
      RD_ISSUE: state_nx = RD_WAIT;
      RD_WAIT:  state_nx = RD_DATA;
      RD_DATA:  state_nx = r_beat ? (at_len ? IDLE : RD_ISSUE) : RD_DATA;
      default:  state_nx = IDLE;
    endcase
  end
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      addr <= '0;
      len <= '0;
      cnt <= '0;
      size <= '0;
      burst <= '0;
      err <= 1'b0;
      last_wr <= 1'b0;
      bus.s_axi_rdata <= '0;
      bus.bram_en <= 1'b0;
      bus.bram_we <= '0;
      bus.bram_addr <= '0;
      bus.bram_wrdata <= '0;
    end else begin
      bus.bram_en <= 1'b0;
      bus.bram_we <= '0;
      if (bus.s_axi_awready) begin
        addr <= bus.s_axi_awaddr[C_ADDR_WIDTH-1:0];
        len <= bus.s_axi_awlen;
        size <= bus.s_axi_awsize;
        burst <= bus.s_axi_awburst;
        cnt <= '0;
        last_wr <= 1'b1;
      end
      if (bus.s_axi_arready) begin
        addr <= bus.s_axi_araddr[C_ADDR_WIDTH-1:0];
        len <= bus.s_axi_arlen;
        size <= bus.s_axi_arsize;
        burst <= bus.s_axi_arburst;
        cnt <= '0;
        last_wr <= 1'b0;
        bus.bram_en <= 1'b1;
        bus.bram_addr <= 32'({bus.s_axi_araddr[C_ADDR_WIDTH-1:2], 2'b00});
      end
      if (w_beat) begin
        bus.bram_en <= 1'b1;
        bus.bram_we <= bus.s_axi_wstrb;
        bus.bram_addr <= 32'({addr[C_ADDR_WIDTH-1:2], 2'b00});
        bus.bram_wrdata <= bus.s_axi_wdata;
        addr <= addr_nx;
        cnt <= cnt + 8'd1;
        if (bus.s_axi_wlast != at_len) err <= 1'b1;
      end
      if (bus.s_axi_bvalid && bus.s_axi_bready) err <= 1'b0;
      if (state == RD_WAIT) bus.s_axi_rdata <= bus.bram_rddata;
      if (r_beat && !at_len) begin
        addr <= addr_nx;
        cnt <= cnt + 8'd1;
        bus.bram_en <= 1'b1;
        bus.bram_addr <= 32'({addr_nx[C_ADDR_WIDTH-1:2], 2'b00});
      end
    end
  end
endmodule

// File: tb/tb_axi_bram_slave.sv
// tb_axi_bram_slave: directed AXI bursts against axi_bram_slave with a behavioural BRAM
module tb_axi_bram_slave;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  axi_bram_slave_if bus();
  axi_bram_slave #(.C_ADDR_WIDTH(12)) dut (.axi_aclk(clk), .axi_areset(rst), .bus(bus.slave));
  int errors = 0, checks = 0, nlog = 0;
  logic [31:0] mem [0:1023];
  logic [31:0] log_a [0:63];
  logic [31:0] log_d [0:63];
  logic [3:0]  log_w [0:63];
  logic [31:0] wd [0:15];
  logic [31:0] rd [0:15];
  logic        rl [0:15];
  int          lat [0:15];
  // one-cycle-latency byte-writable memory behind the BRAM port
  always @(posedge clk) if (bus.bram_en) begin
    for (int b = 0; b < 4; b++)
      if (bus.bram_we[b]) mem[bus.bram_addr[11:2]][8*b +: 8] <= bus.bram_wrdata[8*b +: 8];
    bus.bram_rddata <= mem[bus.bram_addr[11:2]];
  end
  always @(negedge clk) if (bus.bram_en && bus.bram_we != 4'h0 && nlog < 64) begin
    log_a[nlog] = bus.bram_addr;
    log_w[nlog] = bus.bram_we;
    log_d[nlog] = bus.bram_wrdata;
    nlog++;
  end

  task automatic do_write(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                          input logic [3:0] strb, input logic bad_last, output logic [1:0] resp);
    int k;
    @(negedge clk);
    bus.s_axi_awaddr = a; bus.s_axi_awlen = len; bus.s_axi_awsize = 3'd2;
    bus.s_axi_awburst = burst; bus.s_axi_awvalid = 1'b1;
    #1;
    k = 0;
    while (!bus.s_axi_awready && k < 20) begin @(negedge clk); #1; k++; end
    if (k == 20) begin checks++; errors++; $display("FAIL aw_timeout: awready never rose"); end
    @(negedge clk);
    bus.s_axi_awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.s_axi_wdata = wd[i]; bus.s_axi_wstrb = strb;
      bus.s_axi_wlast = bad_last ? (i == 0) : (i == int'(len));
      bus.s_axi_wvalid = 1'b1;
      #1;
      k = 0;
      while (!bus.s_axi_wready && k < 20) begin @(negedge clk); #1; k++; end
      if (k == 20) begin checks++; errors++; $display("FAIL w_timeout: wready never rose"); end
      @(negedge clk);
    end
    bus.s_axi_wvalid = 1'b0; bus.s_axi_wlast = 1'b0;
    #1;
    k = 0;
    while (!bus.s_axi_bvalid && k < 20) begin @(negedge clk); #1; k++; end
    if (k == 20) begin checks++; errors++; $display("FAIL b_timeout: bvalid never rose"); end
    resp = bus.s_axi_bresp;
    bus.s_axi_bready = 1'b1;
    @(negedge clk);
    bus.s_axi_bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst);
    int k, c;
    @(negedge clk);
    bus.s_axi_araddr = a; bus.s_axi_arlen = len; bus.s_axi_arsize = 3'd2;
    bus.s_axi_arburst = burst; bus.s_axi_arvalid = 1'b1;
    #1;
    k = 0;
    while (!bus.s_axi_arready && k < 20) begin @(negedge clk); #1; k++; end
    if (k == 20) begin checks++; errors++; $display("FAIL ar_timeout: arready never rose"); end
    for (int i = 0; i <= int'(len); i++) begin
      @(negedge clk); #1;
      c = 1;
      bus.s_axi_arvalid = 1'b0; bus.s_axi_rready = 1'b0;
      while (!bus.s_axi_rvalid && c < 20) begin @(negedge clk); #1; c++; end
      if (c == 20) begin checks++; errors++; $display("FAIL r_timeout: rvalid never rose"); end
      rd[i] = bus.s_axi_rdata; rl[i] = bus.s_axi_rlast; lat[i] = c;
      bus.s_axi_rready = 1'b1;
    end
    @(negedge clk);
    bus.s_axi_rready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.s_axi_awready, bus.s_axi_arready, bus.s_axi_wready, bus.s_axi_bvalid, bus.s_axi_rvalid,
         bus.s_axi_rlast, bus.s_axi_bresp, bus.s_axi_rresp, bus.s_axi_rdata, bus.bram_en,
         bus.bram_we, bus.bram_addr, bus.bram_wrdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdata=%h bram_addr=%h bram_en=%b expected all zero",
               bus.s_axi_rdata, bus.bram_addr, bus.bram_en);
    end
  endtask

  task automatic test_single();
    int s;
    logic [1:0] resp;
    s = nlog;
    wd[0] = 32'hDEADBEEF;
    do_write(32'h10, 8'd0, 2'b01, 4'hF, 1'b0, resp);
    checks++; if (nlog - s !== 1) begin errors++; $display("FAIL single_wcount: got %0d expected 1", nlog - s); end
    checks++; if ({log_a[s], log_w[s], log_d[s]} !== {32'h10, 4'hF, 32'hDEADBEEF}) begin
      errors++; $display("FAIL single_bram: got %h/%h/%h expected 10/f/deadbeef", log_a[s], log_w[s], log_d[s]); end
    checks++; if (resp !== 2'b00) begin errors++; $display("FAIL single_bresp: got %b expected 00", resp); end
    do_read(32'h10, 8'd0, 2'b01);
    checks++; if (rd[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata: got %h expected deadbeef", rd[0]); end
    checks++; if (rl[0] !== 1'b1) begin errors++; $display("FAIL single_rlast: got %b expected 1", rl[0]); end
    checks++; if (lat[0] !== 3) begin errors++; $display("FAIL single_latency: got %0d expected 3", lat[0]); end
  endtask

  task automatic test_incr_wrap();
    int s;
    logic [1:0] resp;
    s = nlog;
    wd[0] = 32'h11110000; wd[1] = 32'h22220001; wd[2] = 32'h33330002; wd[3] = 32'h44440003;
    do_write(32'hFF8, 8'd3, 2'b01, 4'hF, 1'b0, resp);
    checks++; if (nlog - s !== 4) begin errors++; $display("FAIL incr_wcount: got %0d expected 4", nlog - s); end
    checks++; if ({log_a[s], log_a[s+1], log_a[s+2], log_a[s+3]} !== {32'hFF8, 32'hFFC, 32'h0, 32'h4}) begin
      errors++; $display("FAIL incr_addrs: got %h %h %h %h expected ff8 ffc 0 4", log_a[s], log_a[s+1], log_a[s+2], log_a[s+3]); end
    checks++; if (resp !== 2'b00) begin errors++; $display("FAIL incr_bresp: got %b expected 00", resp); end
    do_read(32'hFF8, 8'd3, 2'b01);
    checks++; if ({rd[0], rd[1], rd[2], rd[3]} !== {32'h11110000, 32'h22220001, 32'h33330002, 32'h44440003}) begin
      errors++; $display("FAIL incr_rdata: got %h %h %h %h expected 11110000 22220001 33330002 44440003", rd[0], rd[1], rd[2], rd[3]); end
    checks++; if ({rl[0], rl[1], rl[2], rl[3]} !== 4'b0001) begin
      errors++; $display("FAIL incr_rlast: got %b%b%b%b expected 0001", rl[0], rl[1], rl[2], rl[3]); end
    checks++; if (lat[3] !== 3) begin errors++; $display("FAIL incr_beat_latency: got %0d expected 3", lat[3]); end
  endtask

  task automatic test_fixed();
    int s;
    logic [1:0] resp;
    s = nlog;
    wd[0] = 32'd1; wd[1] = 32'd2; wd[2] = 32'd3;
    do_write(32'h20, 8'd2, 2'b00, 4'hF, 1'b0, resp);
    checks++; if ({log_a[s], log_a[s+1], log_a[s+2]} !== {3{32'h20}}) begin
      errors++; $display("FAIL fixed_addrs: got %h %h %h expected 20 20 20", log_a[s], log_a[s+1], log_a[s+2]); end
    checks++; if ({log_d[s], log_d[s+1], log_d[s+2]} !== {32'd1, 32'd2, 32'd3}) begin
      errors++; $display("FAIL fixed_data: got %h %h %h expected 1 2 3", log_d[s], log_d[s+1], log_d[s+2]); end
    do_read(32'h20, 8'd0, 2'b00);
    checks++; if (rd[0] !== 32'd3) begin errors++; $display("FAIL fixed_rdata: got %h expected 3", rd[0]); end
  endtask

  task automatic test_strobe_err();
    int s;
    logic [1:0] resp;
    s = nlog;
    wd[0] = 32'h11223344;
    do_write(32'h10, 8'd0, 2'b01, 4'h5, 1'b0, resp);
    checks++; if (log_w[s] !== 4'h5) begin errors++; $display("FAIL strobe_we: got %h expected 5", log_w[s]); end
    do_read(32'h10, 8'd0, 2'b01);
    checks++; if (rd[0] !== 32'hDE22BE44) begin errors++; $display("FAIL strobe_merge: got %h expected de22be44", rd[0]); end
    s = nlog;
    wd[0] = 32'hAAAA0001; wd[1] = 32'hAAAA0002;
    do_write(32'h80, 8'd1, 2'b01, 4'hF, 1'b1, resp);
    checks++; if (nlog - s !== 2) begin errors++; $display("FAIL wlast_beats: got %0d expected 2", nlog - s); end
    checks++; if (resp !== 2'b10) begin errors++; $display("FAIL wlast_slverr: got %b expected 10", resp); end
    wd[0] = 32'h0BADF00D;
    do_write(32'h84, 8'd0, 2'b01, 4'hF, 1'b0, resp);
    checks++; if (resp !== 2'b00) begin errors++; $display("FAIL err_cleared: got %b expected 00", resp); end
  endtask

  task automatic test_backpressure();
    int k;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    bus.s_axi_awaddr = 32'h100; bus.s_axi_awlen = 8'd0; bus.s_axi_awsize = 3'd2; bus.s_axi_awburst = 2'b01;
    bus.s_axi_araddr = 32'h100; bus.s_axi_arlen = 8'd0; bus.s_axi_arsize = 3'd2; bus.s_axi_arburst = 2'b01;
    bus.s_axi_awvalid = 1'b1; bus.s_axi_arvalid = 1'b1;
    #1;
    checks++; if ({bus.s_axi_awready, bus.s_axi_arready} !== 2'b10) begin
      errors++; $display("FAIL arb_write_first: got %b expected 10", {bus.s_axi_awready, bus.s_axi_arready}); end
    @(negedge clk);
    bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wdata = 32'hCAFEF00D; bus.s_axi_wstrb = 4'hF; bus.s_axi_wlast = 1'b1; bus.s_axi_wvalid = 1'b1;
    #1;
    checks++; if ({bus.s_axi_wready, bus.s_axi_arready} !== 2'b10) begin
      errors++; $display("FAIL wready_no_ar: got %b expected 10", {bus.s_axi_wready, bus.s_axi_arready}); end
    @(negedge clk);
    bus.s_axi_wvalid = 1'b0; bus.s_axi_wlast = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++; if ({bus.s_axi_bvalid, bus.s_axi_bresp, bus.s_axi_arready} !== 4'b1000) begin
        errors++; $display("FAIL b_hold: got %b expected 1000", {bus.s_axi_bvalid, bus.s_axi_bresp, bus.s_axi_arready}); end
      @(negedge clk); #1;
    end
    bus.s_axi_bready = 1'b1;
    @(negedge clk);
    bus.s_axi_bready = 1'b0; bus.s_axi_awvalid = 1'b1;
    #1;
    checks++; if ({bus.s_axi_awready, bus.s_axi_arready} !== 2'b01) begin
      errors++; $display("FAIL arb_fair_read: got %b expected 01", {bus.s_axi_awready, bus.s_axi_arready}); end
    @(negedge clk);
    bus.s_axi_awvalid = 1'b0; bus.s_axi_arvalid = 1'b0;
    #1;
    k = 0;
    while (!bus.s_axi_rvalid && k < 20) begin @(negedge clk); #1; k++; end
    if (k == 20) begin checks++; errors++; $display("FAIL r_timeout: rvalid never rose"); end
    for (int i = 0; i < 5; i++) begin
      checks++; if ({bus.s_axi_rvalid, bus.s_axi_rlast, bus.s_axi_rdata} !== {2'b11, 32'hCAFEF00D}) begin
        errors++; $display("FAIL r_hold: got v=%b l=%b d=%h expected 1 1 cafef00d", bus.s_axi_rvalid, bus.s_axi_rlast, bus.s_axi_rdata); end
      @(negedge clk); #1;
    end
    bus.s_axi_rready = 1'b1;
    @(negedge clk);
    bus.s_axi_rready = 1'b0;
    #1;
    checks++; if ({bus.s_axi_rvalid, bus.s_axi_bvalid} !== 2'b00) begin
      errors++; $display("FAIL r_done: got %b expected 00", {bus.s_axi_rvalid, bus.s_axi_bvalid}); end
  endtask

  task automatic test_reset_mid_read();
    int k;
    logic [1:0] resp;
    @(negedge clk);
    bus.s_axi_araddr = 32'hFF8; bus.s_axi_arlen = 8'd3; bus.s_axi_arsize = 3'd2;
    bus.s_axi_arburst = 2'b01; bus.s_axi_arvalid = 1'b1;
    #1;
    k = 0;
    while (!bus.s_axi_arready && k < 20) begin @(negedge clk); #1; k++; end
    if (k == 20) begin checks++; errors++; $display("FAIL ar_timeout: arready never rose"); end
    @(negedge clk);
    bus.s_axi_arvalid = 1'b0;
    #1;
    k = 0;
    while (!bus.s_axi_rvalid && k < 20) begin @(negedge clk); #1; k++; end
    checks++; if (bus.s_axi_rdata !== 32'h11110000) begin
      errors++; $display("FAIL pre_reset_beat: got %h expected 11110000", bus.s_axi_rdata); end
    bus.s_axi_rready = 1'b1;
    @(negedge clk);
    bus.s_axi_rready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({bus.s_axi_awready, bus.s_axi_arready, bus.s_axi_wready, bus.s_axi_bvalid, bus.s_axi_rvalid,
         bus.s_axi_rlast, bus.s_axi_bresp, bus.s_axi_rresp, bus.s_axi_rdata, bus.bram_en,
         bus.bram_we, bus.bram_addr, bus.bram_wrdata} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got rdata=%h bram_addr=%h rvalid=%b expected all zero",
               bus.s_axi_rdata, bus.bram_addr, bus.s_axi_rvalid);
    end
    rst = 1'b0;
    wd[0] = 32'h5A5A1234;
    do_write(32'h200, 8'd0, 2'b01, 4'hF, 1'b0, resp);
    checks++; if (resp !== 2'b00) begin errors++; $display("FAIL post_reset_bresp: got %b expected 00", resp); end
    do_read(32'h200, 8'd0, 2'b01);
    checks++; if ({rd[0], rl[0]} !== {32'h5A5A1234, 1'b1}) begin
      errors++; $display("FAIL post_reset_read: got %h/%b expected 5a5a1234/1", rd[0], rl[0]); end
  endtask

  initial begin
    bus.s_axi_awaddr = '0; bus.s_axi_awlen = '0; bus.s_axi_awsize = '0; bus.s_axi_awburst = '0;
    bus.s_axi_awprot = '0; bus.s_axi_awlock = 1'b0; bus.s_axi_awcache = '0; bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0; bus.s_axi_wlast = 1'b0; bus.s_axi_wvalid = 1'b0;
    bus.s_axi_bready = 1'b0;
    bus.s_axi_araddr = '0; bus.s_axi_arlen = '0; bus.s_axi_arsize = '0; bus.s_axi_arburst = '0;
    bus.s_axi_arprot = '0; bus.s_axi_arlock = 1'b0; bus.s_axi_arcache = '0; bus.s_axi_arvalid = 1'b0;
    bus.s_axi_rready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    test_reset();
    test_single();
    test_incr_wrap();
    test_fixed();
    test_strobe_err();
    test_backpressure();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
